// File: rtl/calc_pkg.sv
// Shared calculator definitions: operation codes, key codes, fixed-point scale and FSM states.
// The calculator core and the key-entry front end both import this package.
package calc_pkg;

   localparam int MAX_INT_DIGITS_DEF = 12;
   localparam int FRAC_DIGITS_DEF    = 6;

   localparam logic [63:0] SCALE = 64'd1_000_000;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_CLR = 3'd5;

   localparam logic [4:0] KEY_POINT = 5'd10;
   localparam logic [4:0] KEY_ADD   = 5'd11;
   localparam logic [4:0] KEY_SUB   = 5'd12;
   localparam logic [4:0] KEY_MUL   = 5'd13;
   localparam logic [4:0] KEY_DIV   = 5'd14;
   localparam logic [4:0] KEY_EQ    = 5'd15;
   localparam logic [4:0] KEY_CLR   = 5'd16;

   localparam logic [63:0] POW10 [0:6] = '{
      64'd1, 64'd10, 64'd100, 64'd1_000, 64'd10_000, 64'd100_000, 64'd1_000_000
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EMIT,
      ST_GAP,
      ST_EMIT2,
      ST_GAP2
   } state_e;

   function automatic logic [2:0] key_to_op(input logic [4:0] key);
      logic [2:0] op;
      case (key)
         KEY_SUB: op = OP_SUB;
         KEY_MUL: op = OP_MUL;
         KEY_DIV: op = OP_DIV;
         default: op = OP_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/digit_accum.sv
// Decimal entry accumulator: builds an unsigned x1e6 fixed-point value from digit and
// point strobes, dropping digits beyond the integer/fraction limits.
module digit_accum
   import calc_pkg::*;
#(
   parameter int MAX_INT_DIGITS = MAX_INT_DIGITS_DEF,
   parameter int FRAC_DIGITS    = FRAC_DIGITS_DEF
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        digit_en_i,
   input  logic [3:0]  digit_i,
   input  logic        point_en_i,
   input  logic        clear_i,
   output logic [63:0] value_o,
   output logic        active_o
);

   localparam logic [3:0] INT_LIM  = 4'(MAX_INT_DIGITS);
   localparam logic [2:0] FRAC_LIM = 3'(FRAC_DIGITS);

   logic [63:0] value_q;
   logic        point_q;
   logic        active_q;
   logic [3:0]  int_cnt_q;
   logic [2:0]  frac_cnt_q;
   logic [2:0]  frac_idx;
   logic [63:0] digit_ext;

   // k-th fraction digit (k = frac_cnt_q + 1) weighs 10^(FRAC_DIGITS - k)
   assign frac_idx  = FRAC_LIM - 3'd1 - frac_cnt_q;
   assign digit_ext = {60'd0, digit_i};

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         value_q    <= 64'd0;
         point_q    <= 1'b0;
         active_q   <= 1'b0;
         int_cnt_q  <= 4'd0;
         frac_cnt_q <= 3'd0;
      end else if (digit_en_i) begin
         active_q <= 1'b1;
         if (!point_q) begin
            if (int_cnt_q < INT_LIM) begin
               value_q   <= value_q * 64'd10 + digit_ext * SCALE;
               int_cnt_q <= int_cnt_q + 4'd1;
            end
         end else if (frac_cnt_q < FRAC_LIM) begin
            value_q    <= value_q + digit_ext * POW10[frac_idx];
            frac_cnt_q <= frac_cnt_q + 3'd1;
         end
      end else if (point_en_i) begin
         active_q <= 1'b1;
         point_q  <= 1'b1;
      end
   end

   assign value_o  = value_q;
   assign active_o = active_q;

endmodule

// File: rtl/key_entry.sv
// Calculator key-entry front end: turns key presses into paced (inputval, op, en)
// transactions, tracking the pending operator, post-'=' state and divide-by-zero error.
module key_entry
   import calc_pkg::*;
#(
   parameter int MAX_INT_DIGITS = MAX_INT_DIGITS_DEF,
   parameter int FRAC_DIGITS    = FRAC_DIGITS_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [4:0]  key_code,
   output logic        key_ready,
   output logic [63:0] inputval,
   output logic [2:0]  op,
   output logic        en,
   output logic [63:0] entry_val,
   output logic        entry_active,
   output logic        err
);

   state_e      state_q;
   logic        key_ready_q;
   logic        en_q;
   logic [63:0] inputval_q;
   logic [2:0]  op_q;
   logic [2:0]  pending_q;
   logic        after_eq_q;
   logic        err_q;
   logic        two_q;
   logic [63:0] second_val_q;

   logic accept, live;
   logic is_digit, is_point, is_oper, is_eq, is_clr;
   logic commit, div_trap, clear_entry;

   assign accept   = key_valid & key_ready_q;
   assign live     = accept & ~err_q;
   assign is_digit = (key_code <= 5'd9);
   assign is_point = (key_code == KEY_POINT);
   assign is_oper  = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
   assign is_eq    = (key_code == KEY_EQ);
   assign is_clr   = (key_code == KEY_CLR);

   assign commit      = live & (is_oper | is_eq) & entry_active;
   assign div_trap    = commit & (pending_q == OP_DIV) & (entry_val == 64'd0);
   assign clear_entry = (accept & is_clr) | commit;

   digit_accum #(
      .MAX_INT_DIGITS(MAX_INT_DIGITS),
      .FRAC_DIGITS   (FRAC_DIGITS)
   ) u_digit_accum (
      .clk_i     (clk),
      .rst_ni    (reset),
      .digit_en_i(live & is_digit),
      .digit_i   (key_code[3:0]),
      .point_en_i(live & is_point),
      .clear_i   (clear_entry),
      .value_o   (entry_val),
      .active_o  (entry_active)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         key_ready_q  <= 1'b1;
         en_q         <= 1'b0;
         inputval_q   <= 64'd0;
         op_q         <= OP_ADD;
         pending_q    <= OP_ADD;
         after_eq_q   <= 1'b0;
         err_q        <= 1'b0;
         two_q        <= 1'b0;
         second_val_q <= 64'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept && is_clr) begin
                  inputval_q  <= 64'd0;
                  op_q        <= OP_CLR;
                  en_q        <= 1'b1;
                  key_ready_q <= 1'b0;
                  state_q     <= ST_EMIT;
                  two_q       <= 1'b0;
                  pending_q   <= OP_ADD;
                  after_eq_q  <= 1'b0;
                  err_q       <= 1'b0;
               end else if (live && (is_oper || is_eq)) begin
                  if (div_trap) begin
                     err_q <= 1'b1;
                  end else if (commit) begin
                     en_q        <= 1'b1;
                     key_ready_q <= 1'b0;
                     state_q     <= ST_EMIT;
                     // After '=' the accumulator holds a stale result: restart it first
                     if (after_eq_q) begin
                        inputval_q   <= 64'd0;
                        op_q         <= OP_CLR;
                        second_val_q <= entry_val;
                        two_q        <= 1'b1;
                     end else begin
                        inputval_q <= entry_val;
                        op_q       <= pending_q;
                        two_q      <= 1'b0;
                     end
                  end
                  if (is_oper) begin
                     pending_q  <= key_to_op(key_code);
                     after_eq_q <= 1'b0;
                  end else if (entry_active) begin
                     after_eq_q <= 1'b1;
                  end
               end
            end
            ST_EMIT: begin
               en_q    <= 1'b0;
               state_q <= ST_GAP;
            end
            ST_GAP: begin
               if (two_q) begin
                  inputval_q <= second_val_q;
                  op_q       <= OP_ADD;
                  en_q       <= 1'b1;
                  two_q      <= 1'b0;
                  state_q    <= ST_EMIT2;
               end else begin
                  key_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            ST_EMIT2: begin
               en_q    <= 1'b0;
               state_q <= ST_GAP2;
            end
            ST_GAP2: begin
               key_ready_q <= 1'b1;
               state_q     <= ST_IDLE;
            end
            default: begin
               en_q        <= 1'b0;
               key_ready_q <= 1'b1;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign key_ready = key_ready_q;
   assign en        = en_q;
   assign inputval  = inputval_q;
   assign op        = op_q;
   assign err       = err_q;

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry: expected transactions are queued as keys are driven
// and matched against every en pulse.
module tb_key_entry;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        key_valid = 1'b0;
   logic [4:0]  key_code = 5'd0;
   logic        key_ready;
   logic [63:0] inputval;
   logic [2:0]  op;
   logic        en;
   logic [63:0] entry_val;
   logic        entry_active;
   logic        err;

   typedef struct {
      logic [63:0] val;
      logic [2:0]  op;
   } txn_t;

   txn_t exp_q[$];
   txn_t exp_t;
   int   checks = 0;
   int   errors = 0;
   logic en_prev = 1'b0;

   always #5 clk = ~clk;

   key_entry dut (
      .clk         (clk),
      .reset       (reset),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_ready   (key_ready),
      .inputval    (inputval),
      .op          (op),
      .en          (en),
      .entry_val   (entry_val),
      .entry_active(entry_active),
      .err         (err)
   );

   // Scoreboard: every en pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (en === 1'b1) begin
         checks++;
         if (en_prev === 1'b1) begin
            errors++;
            $display("FAIL en_single_cycle: en high two cycles running, required one");
         end
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_txn: got inputval=%0d op=%0d, required no transaction",
                     inputval, op);
         end else begin
            exp_t = exp_q.pop_front();
            if (inputval !== exp_t.val || op !== exp_t.op) begin
               errors++;
               $display("FAIL txn: got inputval=%0d op=%0d, required inputval=%0d op=%0d",
                        inputval, op, exp_t.val, exp_t.op);
            end else begin
               $display("TXN inputval=%0d op=%0d", inputval, op);
            end
         end
      end
      en_prev = en;
   end

   function automatic void push(input logic [63:0] v, input logic [2:0] o);
      txn_t t;
      t.val = v;
      t.op  = o;
      exp_q.push_back(t);
   endfunction

   task automatic wait_ready();
      int n;
      n = 0;
      while (key_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL key_ready_timeout: key_ready=%b after %0d cycles, required 1", key_ready, n);
      end
   endtask

   task automatic press(input logic [4:0] c);
      wait_ready();
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   // Drives one key and reports en in the cycle after acceptance and cycles until ready again
   task automatic press_timed(input logic [4:0] c, output logic en_next, output int n);
      wait_ready();
      key_valid = 1'b1;
      key_code  = c;
      @(posedge clk);
      @(negedge clk);
      en_next   = en;
      key_valid = 1'b0;
      n = 1;
      while (key_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic settle();
      wait_ready();
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL txn_missing: %0d expected transactions not seen, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (key_ready !== 1'b1 || en !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: key_ready=%b en=%b err=%b, required 1 0 0", key_ready, en, err);
      end
      checks++;
      if (entry_val !== 64'd0 || entry_active !== 1'b0) begin
         errors++;
         $display("FAIL reset_entry: entry_val=%0d active=%b, required 0 0", entry_val, entry_active);
      end
      checks++;
      if (inputval !== 64'd0 || op !== 3'd0) begin
         errors++;
         $display("FAIL reset_txn: inputval=%0d op=%0d, required 0 0", inputval, op);
      end
   endtask

   task automatic test_add();
      logic e1;
      int   n;
      press(5'd1);
      press(5'd2);
      checks++;
      if (entry_val !== 64'd12_000_000 || entry_active !== 1'b1) begin
         errors++;
         $display("FAIL add_entry: entry_val=%0d active=%b, required 12000000 1", entry_val, entry_active);
      end
      push(64'd12_000_000, 3'd0);
      press(5'd11);
      press(5'd3);
      push(64'd3_000_000, 3'd0);
      press_timed(5'd15, e1, n);
      checks++;
      if (e1 !== 1'b1 || n != 3) begin
         errors++;
         $display("FAIL latency_one: en_next=%b ready_after=%0d, required 1 3", e1, n);
      end
      checks++;
      if (entry_active !== 1'b0 || entry_val !== 64'd0) begin
         errors++;
         $display("FAIL commit_clear: entry_val=%0d active=%b, required 0 0", entry_val, entry_active);
      end
      settle();
   endtask

   task automatic test_frac_mul();
      push(64'd0, 3'd5);
      press(5'd16);
      press(5'd1);
      press(5'd10);
      press(5'd5);
      checks++;
      if (entry_val !== 64'd1_500_000) begin
         errors++;
         $display("FAIL frac_entry: entry_val=%0d, required 1500000", entry_val);
      end
      push(64'd1_500_000, 3'd0);
      press(5'd13);
      press(5'd2);
      push(64'd2_000_000, 3'd2);
      press(5'd15);
      settle();
   endtask

   task automatic test_after_eq();
      logic e1;
      int   n;
      push(64'd0, 3'd5);
      press(5'd16);
      press(5'd4);
      push(64'd4_000_000, 3'd0);
      press(5'd15);
      press(5'd7);
      push(64'd0, 3'd5);
      push(64'd7_000_000, 3'd0);
      press_timed(5'd11, e1, n);
      checks++;
      if (e1 !== 1'b1 || n != 5) begin
         errors++;
         $display("FAIL latency_two: en_next=%b ready_after=%0d, required 1 5", e1, n);
      end
      press(5'd11);
      settle();
   endtask

   task automatic test_div_zero();
      push(64'd0, 3'd5);
      press(5'd16);
      press(5'd9);
      push(64'd9_000_000, 3'd0);
      press(5'd14);
      press(5'd0);
      press(5'd15);
      settle();
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL div_err_set: err=%b, required 1", err);
      end
      press(5'd5);
      checks++;
      if (entry_val !== 64'd0 || entry_active !== 1'b0) begin
         errors++;
         $display("FAIL err_drop: entry_val=%0d active=%b, required 0 0", entry_val, entry_active);
      end
      push(64'd0, 3'd5);
      press(5'd16);
      settle();
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: err=%b, required 0", err);
      end
   endtask

   task automatic test_long_entry();
      for (int i = 0; i < 13; i++) press(5'd1);
      checks++;
      if (entry_val !== 64'd111_111_111_111_000_000) begin
         errors++;
         $display("FAIL int_limit: entry_val=%0d, required 111111111111000000", entry_val);
      end
      press(5'd10);
      for (int d = 1; d <= 7; d++) press(5'(d));
      press(5'd10);
      press(5'd9);
      checks++;
      if (entry_val !== 64'd111_111_111_111_123_456) begin
         errors++;
         $display("FAIL frac_limit: entry_val=%0d, required 111111111111123456", entry_val);
      end
      push(64'd0, 3'd5);
      press(5'd16);
      settle();
   endtask

   task automatic test_ignored();
      press(5'd20);
      checks++;
      if (entry_active !== 1'b0 || key_ready !== 1'b1) begin
         errors++;
         $display("FAIL ignored_code: active=%b key_ready=%b, required 0 1", entry_active, key_ready);
      end
      press(5'd10);
      checks++;
      if (entry_active !== 1'b1 || entry_val !== 64'd0) begin
         errors++;
         $display("FAIL point_only: entry_val=%0d active=%b, required 0 1", entry_val, entry_active);
      end
      push(64'd0, 3'd0);
      press(5'd15);
      press(5'd15);
      settle();
      push(64'd0, 3'd5);
      press(5'd16);
      settle();
   endtask

   task automatic test_reset_mid();
      press(5'd2);
      push(64'd2_000_000, 3'd0);
      press(5'd13);
      press(5'd3);
      wait_ready();
      push(64'd3_000_000, 3'd2);
      key_valid = 1'b1;
      key_code  = 5'd11;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      reset     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (en !== 1'b0 || key_ready !== 1'b1 || entry_val !== 64'd0) begin
         errors++;
         $display("FAIL reset_mid: en=%b key_ready=%b entry_val=%0d, required 0 1 0",
                  en, key_ready, entry_val);
      end
      reset = 1'b1;
      @(negedge clk);
      press(5'd5);
      push(64'd5_000_000, 3'd0);
      press(5'd15);
      settle();
   endtask

   initial begin
      test_reset();
      test_add();
      test_frac_mul();
      test_after_eq();
      test_div_zero();
      test_long_entry();
      test_ignored();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
